conv_encoder_stream: RTL and testbench

- Rate-1/2 feed-forward convolutional encoder; the transmit-side counterpart of tt_um_viterbi_core.
- Accepts one info bit per handshake and emits one 2-bit symbol per handshake on a valid/ready interface that connects directly to the decoder's rx_sym / rx_sym_valid / rx_sym_ready.
- Frames are delimited by in_last. On in_last the block appends M zero tail bits, so each frame ends in state 0, which the decoder's force_state0 mode relies on.

---
 rtl/viterbi_pkg.sv | 29 ++
 rtl/conv_encoder_stream.sv | 126 ++++++++++++
 tb/tb_conv_encoder_stream.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/viterbi_pkg.sv
// Shared convolutional-code helpers used by both the encoder and the Viterbi decoder,
// so the polynomial and bit ordering cannot diverge between the two sides.
package viterbi_pkg;

    localparam int K_DEF = 3;
    localparam int M_DEF = K_DEF - 1;
    localparam int KMAX  = 9;

    localparam logic [KMAX-1:0] G0_DEF = 9'o7;
    localparam logic [KMAX-1:0] G1_DEF = 9'o5;

    typedef enum logic {ST_DATA, ST_TAIL} enc_fsm_e;

    // Callers keep state bits above M at zero and generator bits above K at zero.
    function automatic logic [1:0] conv_sym(input logic [KMAX-2:0] state, input logic b,
                                            input logic [KMAX-1:0] g0, input logic [KMAX-1:0] g1);
        logic [KMAX-1:0] sr;
        sr = {state, b};
        return {^(sr & g0), ^(sr & g1)};
    endfunction

    function automatic logic [KMAX-2:0] conv_next(input logic [KMAX-2:0] state, input logic b,
                                                  input int unsigned m);
        logic [KMAX-2:0] mask;
        mask = (KMAX-1)'((1 << m) - 1);
        return {state[KMAX-3:0], b} & mask;
    endfunction

endpackage

// File: rtl/conv_encoder_stream.sv
// Rate-1/2 feed-forward convolutional encoder with valid/ready streaming and
// optional zero-tail termination so every frame ends in state 0.
module conv_encoder_stream
    import viterbi_pkg::*;
#(
    parameter int           K       = 3,
    parameter logic [K-1:0] G0_OCT  = 3'o7,
    parameter logic [K-1:0] G1_OCT  = 3'o5,
    parameter bit           TAIL_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_bit,
    input  logic       in_last,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [1:0] out_sym,
    output logic       out_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy
);

    localparam int M  = K - 1;
    localparam int TW = $clog2(K);
    localparam logic [KMAX-1:0] G0X = KMAX'(G0_OCT);
    localparam logic [KMAX-1:0] G1X = KMAX'(G1_OCT);

    enc_fsm_e          r_fsm, w_nxt_fsm;
    // Full package width; bits above M are held at zero by conv_next's mask.
    logic [KMAX-2:0]   r_enc, w_nxt_enc;
    logic [TW-1:0]     r_tail_cnt, w_nxt_cnt;
    logic [1:0]        r_sym, w_nxt_sym;
    logic              r_last, w_nxt_last;
    logic              r_valid, w_nxt_valid;
    logic              r_busy, w_nxt_busy;

    logic              w_slot_free;
    logic              w_accept;
    logic              w_bit;
    logic [1:0]        w_sym;
    logic [KMAX-2:0]   w_enc_next;

    assign w_slot_free = !r_valid || out_ready;
    assign in_ready    = (r_fsm == ST_DATA) && w_slot_free;
    assign w_accept    = in_valid && in_ready;
    assign w_bit       = (r_fsm == ST_DATA) ? in_bit : 1'b0;
    assign w_sym       = conv_sym(r_enc, w_bit, G0X, G1X);
    assign w_enc_next  = conv_next(r_enc, w_bit, M);

    assign out_sym   = r_sym;
    assign out_last  = r_last;
    assign out_valid = r_valid;
    assign busy      = r_busy;

    always_comb begin
        w_nxt_fsm   = r_fsm;
        w_nxt_enc   = r_enc;
        w_nxt_cnt   = r_tail_cnt;
        w_nxt_sym   = r_sym;
        w_nxt_last  = r_last;
        w_nxt_valid = r_valid;
        w_nxt_busy  = r_busy;

        // Drain first; a same-cycle load below overrides valid and busy.
        if (r_valid && out_ready) begin
            w_nxt_valid = 1'b0;
            if (r_last) w_nxt_busy = 1'b0;
        end

        case (r_fsm)
            ST_DATA: begin
                if (w_accept) begin
                    w_nxt_sym   = w_sym;
                    w_nxt_valid = 1'b1;
                    w_nxt_busy  = 1'b1;
                    w_nxt_enc   = w_enc_next;
                    w_nxt_last  = 1'b0;
                    if (in_last) begin
                        if (TAIL_EN) begin
                            w_nxt_fsm = ST_TAIL;
                            w_nxt_cnt = TW'(M);
                        end else begin
                            w_nxt_last = 1'b1;
                            w_nxt_enc  = '0;
                        end
                    end
                end
            end
            ST_TAIL: begin
                if (w_slot_free) begin
                    w_nxt_sym   = w_sym;
                    w_nxt_valid = 1'b1;
                    w_nxt_enc   = w_enc_next;
                    w_nxt_cnt   = r_tail_cnt - 1'b1;
                    if (r_tail_cnt == TW'(1)) begin
                        w_nxt_last = 1'b1;
                        w_nxt_fsm  = ST_DATA;
                    end
                end
            end
            default: w_nxt_fsm = ST_DATA;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm      <= ST_DATA;
            r_enc      <= '0;
            r_tail_cnt <= '0;
            r_sym      <= '0;
            r_last     <= 1'b0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_fsm      <= w_nxt_fsm;
            r_enc      <= w_nxt_enc;
            r_tail_cnt <= w_nxt_cnt;
            r_sym      <= w_nxt_sym;
            r_last     <= w_nxt_last;
            r_valid    <= w_nxt_valid;
            r_busy     <= w_nxt_busy;
        end
    end

endmodule

// File: tb/tb_conv_encoder_stream.sv
// Randomized bench for conv_encoder_stream against a frame-level symbol model,
// plus directed impulse / all-ones / back-to-back / reset / no-tail cases.
module tb_conv_encoder_stream;

    localparam int K = 3;
    localparam int M = K - 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_bit, in_last, in_valid, in_ready;
    logic [1:0] out_sym;
    logic       out_last, out_valid, out_ready, busy;

    logic       ib0, il0, iv0, ir0, ol0, ov0, or0, bz0;
    logic [1:0] os0;

    always #5 clk = ~clk;

    conv_encoder_stream #(.K(K), .G0_OCT(3'o7), .G1_OCT(3'o5), .TAIL_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_bit(in_bit), .in_last(in_last), .in_valid(in_valid),
        .in_ready(in_ready), .out_sym(out_sym), .out_last(out_last), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy));

    conv_encoder_stream #(.K(K), .G0_OCT(3'o7), .G1_OCT(3'o5), .TAIL_EN(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_bit(ib0), .in_last(il0), .in_valid(iv0),
        .in_ready(ir0), .out_sym(os0), .out_last(ol0), .out_valid(ov0),
        .out_ready(or0), .busy(bz0));

    int errs = 0;
    int checks = 0;

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Frame-level model: symbols {g0,g1,last} queued at acceptance time.
    int         m_state;
    int         tail_pend;
    bit         busy_m;
    logic [2:0] exp_q[$];
    logic [2:0] obs_q[$];
    bit         ipat_bit[$];
    bit         ipat_last[$];
    int         vprob, rprob;
    bit         prev_stall;
    logic [1:0] prev_sym;
    logic       prev_last;
    bit         chk_noidle, seen_first;

    function automatic logic [2:0] mk(input int st, input int b, input bit last);
        int sr;
        logic [2:0] r;
        sr = st * 2 + b;
        r[2] = ($countones(sr & 'o7) % 2) == 1;
        r[1] = ($countones(sr & 'o5) % 2) == 1;
        r[0] = last;
        return r;
    endfunction

    task automatic model_clear();
        m_state = 0; tail_pend = 0; busy_m = 0;
        exp_q.delete(); obs_q.delete(); ipat_bit.delete(); ipat_last.delete();
        prev_stall = 0; chk_noidle = 0; seen_first = 0;
    endtask

    task automatic step();
        logic [2:0] e;
        bit         acc, hs;
        @(negedge clk);
        out_ready = ($urandom_range(99) < rprob);
        if (ipat_bit.size() > 0 && $urandom_range(99) < vprob) begin
            in_valid = 1'b1; in_bit = ipat_bit[0]; in_last = ipat_last[0];
        end else begin
            in_valid = 1'b0; in_bit = 1'($urandom); in_last = 1'($urandom);
        end
        #1;
        chk("busy", busy, busy_m);
        if (prev_stall) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_sym", out_sym, prev_sym);
            chk("hold_last", out_last, prev_last);
        end
        chk("in_ready", in_ready, (tail_pend == 0) && (!out_valid || out_ready));
        if (chk_noidle && seen_first && (ipat_bit.size() > 0 || exp_q.size() > 0))
            chk("noidle", out_valid, 1);
        if (out_valid) seen_first = 1;
        hs  = out_valid && out_ready;
        acc = in_valid && in_ready;
        if (hs) begin
            obs_q.push_back({out_sym, out_last});
            if (exp_q.size() == 0) chk("extra_sym", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("sym", out_sym, e[2:1]);
                chk("last", out_last, e[0]);
                if (e[0] && !acc) busy_m = 0;
            end
        end
        if (tail_pend > 0 && (!out_valid || out_ready)) tail_pend--;
        if (acc) begin
            void'(ipat_bit.pop_front());
            void'(ipat_last.pop_front());
            busy_m = 1;
            exp_q.push_back(mk(m_state, in_bit, 1'b0));
            m_state = (m_state * 2 + int'(in_bit)) % (1 << M);
            if (in_last) begin
                tail_pend = M;
                for (int t = 0; t < M; t++) begin
                    exp_q.push_back(mk(m_state, 0, t == M - 1));
                    m_state = (m_state * 2) % (1 << M);
                end
            end
        end
        prev_stall = out_valid && !out_ready;
        prev_sym   = out_sym;
        prev_last  = out_last;
    endtask

    task automatic run_stream(input int limit);
        int n = 0;
        while ((ipat_bit.size() > 0 || exp_q.size() > 0 || tail_pend > 0) && n < limit) begin
            step();
            n++;
        end
        chk("timeout", int'(n < limit), 1);
        vprob = 0;
        step();
        step();
    endtask

    task automatic add_bits(input bit b[$], input bit lastflag);
        foreach (b[i]) begin
            ipat_bit.push_back(b[i]);
            ipat_last.push_back(lastflag && (i == b.size() - 1));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic chk_obs(input string tag, input logic [2:0] want[$]);
        chk({tag, "_n"}, obs_q.size(), want.size());
        foreach (want[i])
            if (i < obs_q.size()) chk($sformatf("%s%0d", tag, i), obs_q[i], want[i]);
    endtask

    initial begin
        logic [2:0] imp[$];
        logic [2:0] ones[$];
        bit         bq[$];
        int         n;
        imp  = '{3'b110, 3'b100, 3'b111};
        ones = '{3'b110, 3'b010, 3'b100, 3'b100, 3'b010, 3'b111};
        iv0 = 0; ib0 = 0; il0 = 0; or0 = 1;
        rst_n = 1'b0; in_valid = 0; in_bit = 0; in_last = 0; out_ready = 0;
        model_clear();
        #2;
        chk("rst_valid", out_valid, 0);
        chk("rst_sym", out_sym, 0);
        chk("rst_last", out_last, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk); rst_n = 1'b1;

        // Impulse
        vprob = 100; rprob = 100;
        bq = '{1'b1}; add_bits(bq, 1);
        run_stream(50);
        chk_obs("imp", imp);

        // All-ones, free-running then under backpressure
        model_clear(); vprob = 100; rprob = 100;
        bq = '{1, 1, 1, 1}; add_bits(bq, 1);
        run_stream(50);
        chk_obs("ones", ones);
        model_clear(); vprob = 100; rprob = 45;
        add_bits(bq, 1);
        run_stream(400);
        chk_obs("ones_bp", ones);

        // Back-to-back frames with no bubbles
        model_clear(); vprob = 100; rprob = 100; chk_noidle = 1;
        bq = '{1, 0, 1}; add_bits(bq, 1);
        bq = '{1, 1};    add_bits(bq, 1);
        run_stream(60);
        chk("b2b_n", obs_q.size(), 5 + 2 * M);
        chk_noidle = 0;

        // Random frames, random valid and ready
        model_clear(); vprob = 70; rprob = 60;
        for (int f = 0; f < 8; f++) begin
            bq.delete();
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) bq.push_back(1'($urandom));
            add_bits(bq, 1);
        end
        run_stream(2000);

        // Reset after the first tail symbol is generated
        model_clear(); vprob = 100; rprob = 100;
        bq = '{1'b1}; add_bits(bq, 1);
        n = 0;
        while (obs_q.size() < 1 && n < 20) begin step(); n++; end
        chk("rst_mid_reach", obs_q.size(), 1);
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0;
        #1;
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_busy", busy, 0);
        model_clear();
        @(negedge clk); rst_n = 1'b1;
        vprob = 100; rprob = 100;
        bq = '{1'b1}; add_bits(bq, 1);
        run_stream(50);
        chk_obs("imp2", imp);

        // No-tail variant: frame {1,0}, then frame {1}
        @(negedge clk); iv0 = 1; ib0 = 1; il0 = 0;
        @(negedge clk); #1;
        chk("nt_s0", os0, 2'b11); chk("nt_l0", ol0, 0); chk("nt_v0", ov0, 1);
        ib0 = 0; il0 = 1;
        @(negedge clk); #1;
        chk("nt_s1", os0, 2'b10); chk("nt_l1", ol0, 1); chk("nt_b1", bz0, 1);
        ib0 = 1; il0 = 1;
        @(negedge clk); #1;
        chk("nt_s2", os0, 2'b11); chk("nt_l2", ol0, 1);
        iv0 = 0;
        @(negedge clk); #1;
        chk("nt_v3", ov0, 0); chk("nt_b3", bz0, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
